// File: rtl/tdm_demux4_pkg.sv
// tdm_pkg: shared constants and FSM state type for the 4-slot TDM receive demux
package tdm_pkg;
  localparam int NCH = 4;
  localparam int SLOT_BITS = 2;
  typedef enum logic [1:0] {UNLOCKED, CHECK, LOCKED} state_e;
endpackage

// File: rtl/tdm_demux4_if.sv
// tdm_demux4_if: serial slot input and parallel frame-aligned channel outputs
interface tdm_demux4_if
  import tdm_pkg::*;
#(
  parameter int W = 4
);
  logic                 en;
  logic                 sync;
  logic [W-1:0]         din;
  logic [W-1:0]         y0;
  logic [W-1:0]         y1;
  logic [W-1:0]         y2;
  logic [W-1:0]         y3;
  logic [SLOT_BITS-1:0] s;
  logic                 frame_valid;
  logic                 locked;
  logic                 sync_err;

  modport master (
    output en, sync, din,
    input  y0, y1, y2, y3, s, frame_valid, locked, sync_err
  );

  modport slave (
    input  en, sync, din,
    output y0, y1, y2, y3, s, frame_valid, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux4_slot_ctr.sv
// tdm_slot_ctr: modulo-4 slot counter; a SYNC'd word is slot 0, so load points at slot 1
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic                 load_i,
  output logic [SLOT_BITS-1:0] s_o
);
  logic [SLOT_BITS-1:0] s_q, s_d;

  always_comb s_d = load_i ? SLOT_BITS'(1) : s_q + SLOT_BITS'(1);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s_q <= '0;
    else if (en_i) s_q <= s_d;

  assign s_o = s_q;
endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: tracks slot position and frame alignment, collects a frame of four
// slot words and presents all channels in parallel once per locked frame
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int W = 4
) (
  input logic         clk,
  input logic         rst_n,
  tdm_demux4_if.slave bus
);
  state_e               state_q, state_d;
  logic [SLOT_BITS-1:0] s;
  logic [SLOT_BITS-1:0] wr_idx;
  logic [W-1:0]         shadow_q [3];
  logic [W-1:0]         y_q [NCH];
  logic                 fire_d, err_d, fv_q, err_q;
  logic                 at0, at3;

  tdm_slot_ctr u_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (bus.en),
    .load_i (bus.sync),
    .s_o    (s)
  );

  assign at0    = s == SLOT_BITS'(0);
  assign at3    = s == SLOT_BITS'(3);
  assign wr_idx = bus.sync ? '0 : s;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= UNLOCKED;
    else state_q <= state_d;

  always_comb begin
    state_d = state_q;
    if (bus.en)
      state_d = state_q == UNLOCKED ? (bus.sync ? CHECK : UNLOCKED)
              : state_q == CHECK    ? (at0 ? (bus.sync ? LOCKED : UNLOCKED) : CHECK)
              : (at0 && !bus.sync)  ? UNLOCKED
              : (!at0 && bus.sync)  ? CHECK
              : LOCKED;
  end

  // SYNC landing anywhere but slot 0, or slot 0 arriving without SYNC, breaks lock
  always_comb begin
    fire_d = bus.en && state_q == LOCKED && at3 && !bus.sync;
    err_d  = bus.en && state_q == LOCKED && (at0 != bus.sync);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shadow_q <= '{default: '0};
      y_q      <= '{default: '0};
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      fv_q  <= fire_d;
      err_q <= err_d;
      for (int i = 0; i < 3; i++)
        if (bus.en && wr_idx == SLOT_BITS'(i)) shadow_q[i] <= bus.din;
      if (fire_d) y_q <= '{shadow_q[0], shadow_q[1], shadow_q[2], bus.din};
    end

  assign bus.y0          = y_q[0];
  assign bus.y1          = y_q[1];
  assign bus.y2          = y_q[2];
  assign bus.y3          = y_q[3];
  assign bus.s           = s;
  assign bus.frame_valid = fv_q;
  assign bus.sync_err    = err_q;
  assign bus.locked      = state_q == LOCKED;
endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed slot streams; expected frames and error pulses are queued
// by the driver and matched by a negedge monitor
module tb_tdm_demux4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [15:0] fq [$];
  int eq [$];

  tdm_demux4_if #(.W(4)) bus ();

  tdm_demux4 #(.W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic en, input logic sync, input logic [3:0] d);
    bus.en = en;
    bus.sync = sync;
    bus.din = d;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    bus.sync = 1'b0;
  endtask

  task automatic push_f(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    fq.push_back({d, c, b, a});
  endtask

  always @(negedge clk) if (rst_n) begin
    logic [15:0] e;
    chk("pulse_overlap", {31'd0, bus.frame_valid & bus.sync_err}, 0);
    if (bus.frame_valid) begin
      if (fq.size() == 0) chk("unexpected_frame", {31'd0, bus.frame_valid}, 0);
      else begin
        e = fq.pop_front();
        chk("frame_y", {16'd0, bus.y3, bus.y2, bus.y1, bus.y0}, {16'd0, e});
      end
    end
    if (bus.sync_err) begin
      if (eq.size() == 0) chk("unexpected_sync_err", {31'd0, bus.sync_err}, 0);
      else void'(eq.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.en = 1'b0;
    bus.sync = 1'b0;
    bus.din = '0;
    #23 rst_n = 1'b1;
    #1;
    chk("rst_s", bus.s, 0);
    chk("rst_locked", bus.locked, 0);
    chk("rst_fv", bus.frame_valid, 0);
    chk("rst_y", {bus.y3, bus.y2, bus.y1, bus.y0}, 0);
    // acquisition: first frame only aligns, second frame is delivered
    step(1, 1, 4'hA); step(1, 0, 4'h1); step(1, 0, 4'h2); step(1, 0, 4'h3);
    chk("acq_locked_early", bus.locked, 0);
    chk("acq_s_wrap", bus.s, 0);
    step(1, 1, 4'hB);
    chk("acq_locked", bus.locked, 1);
    chk("acq_s", bus.s, 1);
    step(1, 0, 4'h5); step(1, 0, 4'h6);
    push_f(4'hB, 4'h5, 4'h6, 4'h7);
    step(1, 0, 4'h7);
    chk("acq_y", {bus.y3, bus.y2, bus.y1, bus.y0}, 16'h765B);
    // EN gap between slots 1 and 2
    step(1, 1, 4'hC); step(1, 0, 4'h8);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 4'hF);
      chk("gap_s", bus.s, 2);
      chk("gap_fv", bus.frame_valid, 0);
    end
    step(1, 0, 4'h9);
    push_f(4'hC, 4'h8, 4'h9, 4'hA);
    step(1, 0, 4'hA);
    chk("gap_locked", bus.locked, 1);
    // missing SYNC on slot 0
    eq.push_back(1);
    step(1, 0, 4'hD);
    chk("miss_err", bus.sync_err, 1);
    chk("miss_locked", bus.locked, 0);
    chk("miss_y_hold", {bus.y3, bus.y2, bus.y1, bus.y0}, 16'hA98C);
    step(1, 0, 4'hE); step(1, 0, 4'hF); step(1, 0, 4'h1);
    chk("miss_err_drop", bus.sync_err, 0);
    // reacquire
    step(1, 1, 4'h2); step(1, 0, 4'h3); step(1, 0, 4'h4); step(1, 0, 4'h5);
    step(1, 1, 4'h6); step(1, 0, 4'h7); step(1, 0, 4'h8);
    push_f(4'h6, 4'h7, 4'h8, 4'h9);
    step(1, 0, 4'h9);
    // early SYNC at slot 2
    step(1, 1, 4'hA); step(1, 0, 4'hB);
    eq.push_back(1);
    step(1, 1, 4'hC);
    chk("early_err", bus.sync_err, 1);
    chk("early_s", bus.s, 1);
    chk("early_locked", bus.locked, 0);
    step(1, 0, 4'hD); step(1, 0, 4'hE); step(1, 0, 4'hF);
    step(1, 1, 4'h1);
    chk("early_relock", bus.locked, 1);
    step(1, 0, 4'h2); step(1, 0, 4'h3);
    push_f(4'h1, 4'h2, 4'h3, 4'h4);
    step(1, 0, 4'h4);
    // SYNC at slot 3
    step(1, 1, 4'h5); step(1, 0, 4'h6); step(1, 0, 4'h7);
    chk("s3_pre_s", bus.s, 3);
    eq.push_back(1);
    step(1, 1, 4'h8);
    chk("s3_err", bus.sync_err, 1);
    chk("s3_fv", bus.frame_valid, 0);
    chk("s3_s", bus.s, 1);
    chk("s3_y_hold", {bus.y3, bus.y2, bus.y1, bus.y0}, 16'h4321);
    // load all-F frame then assert reset mid-stream without a clock edge
    step(1, 0, 4'h9); step(1, 0, 4'hA); step(1, 0, 4'hB);
    step(1, 1, 4'hF); step(1, 0, 4'hF); step(1, 0, 4'hF);
    push_f(4'hF, 4'hF, 4'hF, 4'hF);
    step(1, 0, 4'hF);
    step(1, 1, 4'hF);
    chk("pre_rst_y", {bus.y3, bus.y2, bus.y1, bus.y0}, 16'hFFFF);
    rst_n = 1'b0;
    #1;
    chk("async_rst_y", {bus.y3, bus.y2, bus.y1, bus.y0}, 0);
    chk("async_rst_s", bus.s, 0);
    chk("async_rst_locked", bus.locked, 0);
    #10 rst_n = 1'b1;
    step(1, 0, 4'h1);
    chk("post_rst_locked", bus.locked, 0);
    chk("post_rst_s", bus.s, 1);
    step(0, 0, 4'h0); step(0, 0, 4'h0);
    chk("frames_pending", fq.size(), 0);
    chk("errs_pending", eq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
